// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Segment patterns are active-low, bit0 = segment a.
package seven_seg_pkg;

    typedef enum logic [1:0] {
        S_BLANK,
        S_ON,
        S_OFF
    } scan_state_e;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam int unsigned ON_WINDOW = 16;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seven_seg_decode.sv
// Hex nibble to active-low seven-segment pattern (gfedcba).
module seven_seg_decode
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);

    assign pattern = HEX_SEG[nibble];

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller: one digit per slot, blank phase then PWM on-window.
// Config is double-buffered; a pending snapshot becomes active only at the digit wrap.
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS       = 4,
    parameter int unsigned TICK_DIV         = 1000,
    parameter int unsigned BLANK_TICKS      = 2,
    parameter int unsigned ANODE_ACTIVE_LOW = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [4*NUM_DIGITS-1:0] cfg_digits,
    input  logic [NUM_DIGITS-1:0]   cfg_dp,
    input  logic [NUM_DIGITS-1:0]   cfg_en,
    input  logic [3:0]              cfg_bright,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_done
);

    localparam int unsigned PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned IW        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned PHASE_MAX = (BLANK_TICKS > ON_WINDOW) ? BLANK_TICKS : ON_WINDOW;
    localparam int unsigned CW        = $clog2(PHASE_MAX + 1);

    localparam logic [PW-1:0] LAST_PRESC = PW'(TICK_DIV - 1);
    localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ANODE_IDLE =
        (ANODE_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    logic [PW-1:0] presc_q;
    logic          tick;
    logic [CW-1:0] tick_cnt_q, tick_cnt_d;
    logic [CW-1:0] phase_len;
    logic          phase_end;
    logic          wrap;
    logic          accept;

    scan_state_e   state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;

    logic [4*NUM_DIGITS-1:0] active_digits_q, pending_digits_q;
    logic [NUM_DIGITS-1:0]   active_dp_q, pending_dp_q;
    logic [NUM_DIGITS-1:0]   active_en_q, pending_en_q;
    logic [3:0]              active_bright_q, pending_bright_q;
    logic                    pending_full_q;

    logic [3:0]            digit_nibble;
    logic [6:0]            digit_pattern;
    logic [NUM_DIGITS-1:0] sel_onehot;
    logic [NUM_DIGITS-1:0] anode_d;
    logic [6:0]            seg_d;
    logic                  dp_d;

    assign tick      = (presc_q == LAST_PRESC);
    assign cfg_ready = ~pending_full_q;
    assign accept    = cfg_valid & ~pending_full_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= tick ? '0 : presc_q + PW'(1);
        end
    end

    always_comb begin
        phase_len = CW'(BLANK_TICKS);
        case (state_q)
            S_BLANK: phase_len = CW'(BLANK_TICKS);
            S_ON:    phase_len = CW'(active_bright_q);
            S_OFF:   phase_len = CW'(ON_WINDOW) - CW'(active_bright_q);
            default: phase_len = CW'(BLANK_TICKS);
        endcase
    end

    assign phase_end = tick && (tick_cnt_q == phase_len - CW'(1));

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        tick_cnt_d = tick_cnt_q;
        wrap       = 1'b0;
        if (tick) begin
            if (phase_end) begin
                tick_cnt_d = '0;
                case (state_q)
                    S_BLANK: state_d = (active_bright_q == 4'd0) ? S_OFF : S_ON;
                    // Brightness tops out at 15, so the on-phase is always followed by an off-phase.
                    S_ON:    state_d = S_OFF;
                    S_OFF: begin
                        state_d = S_BLANK;
                        if (idx_q == LAST_IDX) begin
                            idx_d = '0;
                            wrap  = 1'b1;
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end
                    default: state_d = S_BLANK;
                endcase
            end else begin
                tick_cnt_d = tick_cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_BLANK;
            idx_q      <= '0;
            tick_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            tick_cnt_q <= tick_cnt_d;
        end
    end

    // Pending can only be full or accepting in a given cycle, never both.
    always_ff @(posedge clock) begin
        if (reset) begin
            active_digits_q  <= '0;
            active_dp_q      <= '0;
            active_en_q      <= '0;
            active_bright_q  <= '0;
            pending_digits_q <= '0;
            pending_dp_q     <= '0;
            pending_en_q     <= '0;
            pending_bright_q <= '0;
            pending_full_q   <= 1'b0;
        end else begin
            if (wrap && pending_full_q) begin
                active_digits_q <= pending_digits_q;
                active_dp_q     <= pending_dp_q;
                active_en_q     <= pending_en_q;
                active_bright_q <= pending_bright_q;
                pending_full_q  <= 1'b0;
            end
            if (accept) begin
                pending_digits_q <= cfg_digits;
                pending_dp_q     <= cfg_dp;
                pending_en_q     <= cfg_en;
                pending_bright_q <= cfg_bright;
                pending_full_q   <= 1'b1;
            end
        end
    end

    assign digit_nibble = active_digits_q[idx_d*4 +: 4];

    seven_seg_decode u_decode (
        .nibble  (digit_nibble),
        .pattern (digit_pattern)
    );

    // Outputs are computed from the next state so they line up with the phase registers.
    always_comb begin
        sel_onehot        = '0;
        sel_onehot[idx_d] = 1'b1;
        anode_d           = ANODE_IDLE;
        seg_d             = SEG_OFF;
        dp_d              = 1'b1;
        if (state_d == S_ON && active_en_q[idx_d]) begin
            anode_d = (ANODE_ACTIVE_LOW != 0) ? ~sel_onehot : sel_onehot;
            seg_d   = digit_pattern;
            dp_d    = ~active_dp_q[idx_d];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            anode      <= ANODE_IDLE;
            seg        <= SEG_OFF;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            anode      <= anode_d;
            seg        <= seg_d;
            dp         <= dp_d;
            frame_done <= wrap;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench for seven_seg_scan_ctrl: a cycle-count reference model predicts every
// output cycle, a monitor compares the DUT against those predictions.
module tb_seven_seg_scan_ctrl;

    localparam int ND        = 4;
    localparam int TD        = 4;
    localparam int BT        = 1;
    localparam int SLOT      = BT + 16;
    localparam int FRAME_CYC = ND * SLOT * TD;

    // Active-high gfedcba patterns for 0..F.
    localparam logic [6:0] HI_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [15:0] cfg_digits = '0;
    logic [3:0]  cfg_dp = '0;
    logic [3:0]  cfg_en = '0;
    logic [3:0]  cfg_bright = '0;
    logic [3:0]  anode;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int vectors    = 0;
    int miscompares = 0;
    logic [13:0] exp_q [$];

    always #5 clock = ~clock;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS       (ND),
        .TICK_DIV         (TD),
        .BLANK_TICKS      (BT),
        .ANODE_ACTIVE_LOW (1)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_digits (cfg_digits),
        .cfg_dp     (cfg_dp),
        .cfg_en     (cfg_en),
        .cfg_bright (cfg_bright),
        .anode      (anode),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    // Expected {anode, seg, dp, frame_done, cfg_ready} in cycle t after reset release.
    function automatic logic [13:0] expect_at(input int t, input logic [27:0] cfg,
                                              input bit pend_full);
        int n, f, s, p;
        logic [15:0] digs;
        logic [3:0]  dpm, en, br, nib, an;
        logic [6:0]  sg;
        logic        d, fd;
        n    = t / TD;
        f    = n % (ND * SLOT);
        s    = f / SLOT;
        p    = f % SLOT;
        digs = cfg[27:12];
        dpm  = cfg[11:8];
        en   = cfg[7:4];
        br   = cfg[3:0];
        an   = 4'hF;
        sg   = 7'h7F;
        d    = 1'b1;
        if (p >= BT && p < BT + int'(br) && en[s]) begin
            nib = digs[s*4 +: 4];
            an  = ~(4'b0001 << s);
            sg  = ~HI_SEG[nib];
            d   = ~dpm[s];
        end
        fd = (t > 0) && (t % FRAME_CYC == 0);
        return {an, sg, d, fd, ~pend_full};
    endfunction

    // Reference model: advances one cycle per edge, handles reset, handshake and frame wrap.
    initial begin : model
        int          t;
        bit          pend_full;
        bit          acc;
        logic [27:0] act;
        logic [27:0] pend;
        logic [13:0] e;
        t = 0;
        pend_full = 0;
        act = '0;
        pend = '0;
        forever begin
            @(posedge clock);
            if (reset) begin
                t = 0;
                pend_full = 0;
                act = '0;
                pend = '0;
                e = {4'hF, 7'h7F, 1'b1, 1'b0, 1'b1};
            end else begin
                acc = cfg_valid && !pend_full;
                if ((t % FRAME_CYC) == FRAME_CYC - 1 && pend_full) begin
                    act = pend;
                    pend_full = 0;
                end
                if (acc) begin
                    pend = {cfg_digits, cfg_dp, cfg_en, cfg_bright};
                    pend_full = 1;
                end
                t++;
                e = expect_at(t, act, pend_full);
            end
            exp_q.push_back(e);
        end
    end

    initial begin : monitor
        logic [13:0] e;
        logic [13:0] got;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {anode, seg, dp, frame_done, cfg_ready};
                vectors++;
                if (got !== e) begin
                    miscompares++;
                    $display("FAIL outputs @%0t: got anode=%h seg=%h dp=%b fd=%b rdy=%b, want anode=%h seg=%h dp=%b fd=%b rdy=%b",
                             $time, got[13:10], got[9:3], got[2], got[1], got[0],
                             e[13:10], e[9:3], e[2], e[1], e[0]);
                end
            end
        end
    end

    // Holds the offer until the DUT takes it; a stuck cfg_ready is reported as a failure.
    task automatic offer(input logic [15:0] d, input logic [3:0] p, input logic [3:0] e,
                         input logic [3:0] b);
        int waited;
        waited     = 0;
        cfg_digits = d;
        cfg_dp     = p;
        cfg_en     = e;
        cfg_bright = b;
        cfg_valid  = 1'b1;
        while (1) begin
            @(negedge clock);
            if (cfg_ready) break;
            waited++;
            if (waited > 2 * FRAME_CYC) begin
                vectors++;
                miscompares++;
                $display("FAIL handshake: cfg_ready=0 for %0d cycles, want 1 within a frame",
                         waited);
                break;
            end
        end
        @(posedge clock);
        #1;
        cfg_valid  = 1'b0;
        cfg_digits = 16'($urandom);
    endtask

    initial begin : stimulus
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        offer(16'h1234, 4'h1, 4'hF, 4'd15);
        // Second offer is back-pressured until the first wrap.
        offer(16'($urandom), 4'($urandom), 4'b0101, 4'd4);
        offer(16'($urandom), 4'($urandom), 4'($urandom), 4'd0);
        for (int i = 0; i < 4; i++) begin
            offer(16'($urandom), 4'($urandom), 4'($urandom), 4'($urandom_range(0, 15)));
        end

        // Full brightness becomes active, then a config is left pending and reset hits mid on-time.
        offer(16'($urandom), 4'($urandom), 4'hF, 4'd15);
        offer(16'hABCD, 4'hF, 4'hF, 4'd9);
        repeat (20) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;

        repeat (2 * FRAME_CYC + 10) @(posedge clock);
        repeat (2) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
